// File: rtl/sbox_word_arbiter.sv
// rtl/sbox_word_arbiter.sv - round-robin sharing of one registered byte S-box between two word requesters
module sbox_word_arbiter #(
   parameter int NUM_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req0_valid,
   input  logic [8*NUM_BYTES-1:0] req0_data,
   output logic                   req0_ready,
   input  logic                   req1_valid,
   input  logic [8*NUM_BYTES-1:0] req1_data,
   output logic                   req1_ready,
   output logic                   res_valid,
   output logic                   res_id,
   output logic [8*NUM_BYTES-1:0] res_data,
   output logic                   busy,
   output logic                   sbox_valid,
   output logic [7:0]             sbox_din,
   input  logic [7:0]             sbox_dout
);

   localparam int W  = 8 * NUM_BYTES;
   localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t        state;
   logic          last_grant;
   logic          pend_id;
   logic [CW-1:0] issue_cnt;
   logic [CW-1:0] cap_cnt;
   logic [W-1:0]  issue_shift;
   logic [W-1:0]  cap_word;
   logic [W-1:0]  cap_next;
   logic [W-1:0]  sel_data;
   logic          grant0;
   logic          grant1;
   logic          cap_en;

   // last_grant names the port served most recently; the other port wins a tie
   assign grant0     = req0_valid & (~req1_valid | last_grant);
   assign grant1     = req1_valid & (~req0_valid | ~last_grant);
   assign req0_ready = (state == IDLE) & grant0;
   assign req1_ready = (state == IDLE) & grant1;
   assign sel_data   = grant1 ? req1_data : req0_data;

   // sbox_dout lags the issued byte by one cycle, so the first ISSUE cycle has nothing to capture
   assign cap_en = ((state == ISSUE) && (issue_cnt != '0)) || (state == DRAIN);

   always_comb begin
      cap_next = cap_word;
      if (cap_en) begin
         cap_next[{cap_cnt, 3'b000} +: 8] = sbox_dout;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         pend_id     <= 1'b0;
         issue_cnt   <= '0;
         cap_cnt     <= '0;
         issue_shift <= '0;
         cap_word    <= '0;
         res_valid   <= 1'b0;
         res_id      <= 1'b0;
         res_data    <= '0;
         busy        <= 1'b0;
         sbox_valid  <= 1'b0;
         sbox_din    <= 8'h00;
      end else begin
         res_valid <= 1'b0;
         if (cap_en) begin
            cap_word <= cap_next;
            cap_cnt  <= cap_cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               if (grant0 | grant1) begin
                  state       <= ISSUE;
                  busy        <= 1'b1;
                  last_grant  <= grant1;
                  pend_id     <= grant1;
                  issue_shift <= sel_data >> 8;
                  issue_cnt   <= '0;
                  cap_cnt     <= '0;
                  sbox_valid  <= 1'b1;
                  sbox_din    <= sel_data[7:0];
               end
            end
            ISSUE: begin
               if (issue_cnt == LAST_IDX) begin
                  state      <= DRAIN;
                  sbox_valid <= 1'b0;
                  sbox_din   <= 8'h00;
               end else begin
                  issue_cnt   <= issue_cnt + 1'b1;
                  sbox_din    <= issue_shift[7:0];
                  issue_shift <= issue_shift >> 8;
               end
            end
            DRAIN: begin
               state     <= DONE;
               res_valid <= 1'b1;
               res_id    <= pend_id;
               res_data  <= cap_next;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
